// File: rtl/tanh_batch_driver.sv
// -----------------------------------------------------------------------------
// tanh_batch_driver
//
// Purpose:
//   Feeds a batch of operands, one at a time, to an external iterative tanh
//   core and collects its results. Operands are preloaded into an operand
//   buffer. On start, each operand is presented on core_z0 while the core is
//   held in reset for RST_CYCLES cycles. The core is then released and the
//   driver waits for a rising edge on core_flag. The core result is then
//   stored in the result buffer. If the core never flags within TIMEOUT
//   cycles, 16'hFFFF is stored instead and the sticky err flag is raised.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   rst        - asynchronous, active-low reset
//   wr_en      - write operand buffer entry wr_addr with wr_data (any state)
//   wr_addr    - operand write address
//   wr_data    - operand value (core z0 format)
//   count      - number of operands to process (1..DEPTH), sampled at start
//   start      - begin a batch; only accepted while idle
//   rd_addr    - result read address
//   rd_data    - result buffer entry at rd_addr, one cycle later
//   core_z0    - operand currently presented to the tanh core
//   core_rst   - active-high reset to the tanh core
//   core_flag  - core result-valid flag, a rising edge means result ready
//   core_out   - core result
//   busy       - a batch is in progress
//   done       - one-cycle pulse when a batch completes
//   err        - sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module tanh_batch_driver #(
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 64,
  parameter int RST_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [15:0]                wr_data,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic                       start,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [15:0]                rd_data,
  output logic [15:0]                core_z0,
  output logic                       core_rst,
  input  logic                       core_flag,
  input  logic [15:0]                core_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESTART = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_nextState;

  logic [AW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_tcnt;
  logic [RW-1:0]   r_rcnt;
  logic            r_flagPrev;
  logic            r_err;
  logic            r_timedOut;
  logic [15:0]     r_coreZ0;
  logic [15:0]     r_rdData;

  logic [15:0]     r_opBuf  [DEPTH];
  logic [15:0]     r_resBuf [DEPTH];

  logic            w_startOk;
  logic            w_edge;
  logic            w_rstDone;
  logic            w_timeout;
  logic            w_lastIdx;
  logic [AW-1:0]   w_nextIdx;

  // A start is only meaningful with a count the buffer can actually hold.
  assign w_startOk = start && (count != '0) && (count <= CW'(DEPTH));
  assign w_edge    = core_flag && !r_flagPrev;
  assign w_rstDone = (r_rcnt == RW'(RST_CYCLES - 1));
  assign w_timeout = (r_tcnt == TW'(TIMEOUT - 1));
  assign w_lastIdx = ({1'b0, r_idx} == (r_cnt - 1'b1));
  assign w_nextIdx = r_idx + 1'b1;

  assign core_z0 = r_coreZ0;
  assign rd_data = r_rdData;
  assign err     = r_err;

  // State register. Reset drops straight back to IDLE, which also makes
  // busy/done/core_rst take their idle values without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and output decode. The core is held in reset whenever no
  // operand is being computed; it only runs during WAIT and CAPTURE.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    core_rst    = 1'b0;
    case (r_state)
      IDLE: begin
        busy     = 1'b0;
        core_rst = 1'b1;
        if (w_startOk) begin
          w_nextState = RESTART;
        end
      end
      RESTART: begin
        core_rst = 1'b1;
        if (w_rstDone) begin
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        if (w_edge || w_timeout) begin
          w_nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        w_nextState = w_lastIdx ? FINISH : RESTART;
      end
      FINISH: begin
        done        = 1'b1;
        core_rst    = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Batch bookkeeping: operand index, restart and timeout counters, the
  // sticky error flag and the operand latched onto core_z0. core_z0 is
  // loaded only when entering RESTART, so buffer writes to the in-flight
  // entry cannot disturb an operand the core is already working on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_tcnt     <= '0;
      r_rcnt     <= '0;
      r_err      <= 1'b0;
      r_timedOut <= 1'b0;
      r_coreZ0   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startOk) begin
            r_cnt      <= count;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_rcnt     <= '0;
            r_tcnt     <= '0;
            r_timedOut <= 1'b0;
            r_coreZ0   <= r_opBuf[0];
          end
        end
        RESTART: begin
          r_tcnt <= '0;
          if (!w_rstDone) begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
        WAIT: begin
          if (w_edge) begin
            r_timedOut <= 1'b0;
          end else if (w_timeout) begin
            r_timedOut <= 1'b1;
            r_err      <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (!w_lastIdx) begin
            r_idx      <= w_nextIdx;
            r_rcnt     <= '0;
            r_timedOut <= 1'b0;
            r_coreZ0   <= r_opBuf[w_nextIdx];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Flag edge detector. While the core is held in reset the previous value
  // is pinned high, so a flag still high from the previous operand cannot
  // be mistaken for a fresh result on the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flagPrev <= 1'b1;
    end else begin
      r_flagPrev <= core_rst ? 1'b1 : core_flag;
    end
  end

  // Registered result read port. A capture to the same address in the same
  // cycle returns the old contents, which falls out of the non-blocking
  // write below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdData <= '0;
    end else begin
      r_rdData <= r_resBuf[rd_addr];
    end
  end

  // Operand and result storage. Neither buffer is cleared by reset; host
  // writes are accepted in every state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_opBuf[wr_addr] <= wr_data;
    end
    if (r_state == CAPTURE) begin
      r_resBuf[r_idx] <= r_timedOut ? 16'hFFFF : core_out;
    end
  end

endmodule

// File: tb/tb_tanh_batch_driver.sv
// -----------------------------------------------------------------------------
// tb_tanh_batch_driver
//
// Directed bench for tanh_batch_driver. A small behavioural core answers
// each operand CORE_LAT cycles after release with the bitwise inverse of
// core_z0, which keeps every expected result easy to derive by hand.
// -----------------------------------------------------------------------------
module tb_tanh_batch_driver;

   localparam int DEPTH    = 8;
   localparam int CORE_LAT = 20;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        wr_en    = 1'b0;
   logic [2:0]  wr_addr  = '0;
   logic [15:0] wr_data  = '0;
   logic [3:0]  count    = '0;
   logic        start    = 1'b0;
   logic [2:0]  rd_addr  = '0;
   logic [15:0] rd_data;
   logic [15:0] core_z0;
   logic        core_rst;
   logic        coreFlag = 1'b0;
   logic [15:0] coreOut  = '0;
   logic        busy;
   logic        done;
   logic        err;

   int          checks    = 0;
   int          errors    = 0;
   int          cyc       = 0;
   int          doneCount = 0;
   int          doneCyc   = 0;
   int          startCyc  = 0;
   int          doneBase  = 0;
   int          coreCnt   = 0;
   bit          stuckHigh = 1'b0;
   bit          suppressEn = 1'b0;
   logic [15:0] suppressVal = '0;
   logic [15:0] rdVal;

   logic [15:0] fullOps [8] = '{16'h0003, 16'h0030, 16'h0300, 16'h3000,
                                16'hC000, 16'h0C00, 16'h00C0, 16'h000C};
   logic [15:0] fullExp [8] = '{16'hFFFC, 16'hFFCF, 16'hFCFF, 16'hCFFF,
                                16'h3FFF, 16'hF3FF, 16'hFF3F, 16'hFFF3};

   tanh_batch_driver #(
      .DEPTH(DEPTH),
      .TIMEOUT(64),
      .RST_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .count(count),
      .start(start),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .core_z0(core_z0),
      .core_rst(core_rst),
      .core_flag(coreFlag),
      .core_out(coreOut),
      .busy(busy),
      .done(done),
      .err(err)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Cycle counter and done-pulse monitor; doneCyc records the cycle of
   // the most recent pulse so batch latency can be measured from start.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) begin
         doneCount <= doneCount + 1;
         doneCyc   <= cyc;
      end
   end

   // Behavioural tanh core. It raises its flag CORE_LAT cycles after being
   // released. In stuck mode the flag survives reset and drops a couple of
   // cycles after release, and suppression makes one chosen operand hang.
   always @(posedge clk) begin
      if (core_rst) begin
         coreCnt <= 0;
         if (!stuckHigh) begin
            coreFlag <= 1'b0;
         end
      end else begin
         coreCnt <= coreCnt + 1;
         if (stuckHigh && coreCnt == 2) begin
            coreFlag <= 1'b0;
         end
         if (coreCnt == CORE_LAT - 1 && !(suppressEn && core_z0 == suppressVal)) begin
            coreFlag <= 1'b1;
            coreOut  <= ~core_z0;
         end
      end
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic writeOp(input logic [2:0] a, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Pulse start for one cycle with the given count.
   task automatic applyStimulus(input logic [3:0] n);
      count    = n;
      start    = 1'b1;
      startCyc = cyc;
      doneBase = doneCount;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic waitIdle(input string tag, input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checkOutput(tag, 16'(ok), 16'h0001);
   endtask

   task automatic readRes(input logic [2:0] a, output logic [15:0] d);
      rd_addr = a;
      @(negedge clk);
      d = rd_data;
   endtask

   // Backstop so a wedged design still ends the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_busy", 16'(busy), 16'h0000);
      checkOutput("rst_done", 16'(done), 16'h0000);
      checkOutput("rst_err", 16'(err), 16'h0000);
      checkOutput("rst_core_rst", 16'(core_rst), 16'h0001);
      checkOutput("rst_core_z0", core_z0, 16'h0000);
      checkOutput("rst_rd_data", rd_data, 16'h0000);
      tick(2);
      rst = 1'b1;
      tick(1);

      $display("[TB] basic batch of three");
      writeOp(3'd0, 16'h0100);
      writeOp(3'd1, 16'h0800);
      writeOp(3'd2, 16'hF800);
      applyStimulus(4'd3);
      checkOutput("main_busy", 16'(busy), 16'h0001);
      checkOutput("main_core_rst_restart", 16'(core_rst), 16'h0001);
      checkOutput("main_z0_op0", core_z0, 16'h0100);
      tick(3);
      checkOutput("main_core_rst_wait", 16'(core_rst), 16'h0000);
      waitIdle("main_idle", 200);
      checkOutput("main_done_count", 16'(doneCount - doneBase), 16'h0001);
      checkOutput("main_latency", 16'(doneCyc - startCyc), 16'd73);
      checkOutput("main_err", 16'(err), 16'h0000);
      readRes(3'd0, rdVal); checkOutput("main_res0", rdVal, 16'hFEFF);
      readRes(3'd1, rdVal); checkOutput("main_res1", rdVal, 16'hF7FF);
      readRes(3'd2, rdVal); checkOutput("main_res2", rdVal, 16'h07FF);

      $display("[TB] timeout on second operand");
      writeOp(3'd0, 16'h00FF);
      writeOp(3'd1, 16'h7777);
      suppressVal = 16'h7777;
      suppressEn  = 1'b1;
      applyStimulus(4'd2);
      waitIdle("tmo_idle", 300);
      suppressEn  = 1'b0;
      checkOutput("tmo_done_count", 16'(doneCount - doneBase), 16'h0001);
      checkOutput("tmo_latency", 16'(doneCyc - startCyc), 16'd92);
      checkOutput("tmo_err", 16'(err), 16'h0001);
      readRes(3'd0, rdVal); checkOutput("tmo_res0", rdVal, 16'hFF00);
      readRes(3'd1, rdVal); checkOutput("tmo_res1", rdVal, 16'hFFFF);

      $display("[TB] out-of-range counts");
      applyStimulus(4'd0);
      checkOutput("cnt0_busy", 16'(busy), 16'h0000);
      tick(3);
      checkOutput("cnt0_done", 16'(doneCount - doneBase), 16'h0000);
      applyStimulus(4'd9);
      checkOutput("cnt9_busy", 16'(busy), 16'h0000);
      tick(3);
      checkOutput("cnt9_done", 16'(doneCount - doneBase), 16'h0000);
      checkOutput("cnt_err_sticky", 16'(err), 16'h0001);

      $display("[TB] flag stuck high between operands");
      writeOp(3'd0, 16'h1234);
      writeOp(3'd1, 16'hABCD);
      writeOp(3'd2, 16'h0001);
      stuckHigh = 1'b1;
      applyStimulus(4'd3);
      checkOutput("stuck_err_cleared", 16'(err), 16'h0000);
      waitIdle("stuck_idle", 200);
      stuckHigh = 1'b0;
      checkOutput("stuck_done_count", 16'(doneCount - doneBase), 16'h0001);
      checkOutput("stuck_latency", 16'(doneCyc - startCyc), 16'd73);
      readRes(3'd0, rdVal); checkOutput("stuck_res0", rdVal, 16'hEDCB);
      readRes(3'd1, rdVal); checkOutput("stuck_res1", rdVal, 16'h5432);
      readRes(3'd2, rdVal); checkOutput("stuck_res2", rdVal, 16'hFFFE);

      $display("[TB] reset during second operand");
      writeOp(3'd0, 16'h4000);
      writeOp(3'd1, 16'h2000);
      writeOp(3'd2, 16'h1000);
      applyStimulus(4'd3);
      tick(29);
      checkOutput("mid_busy", 16'(busy), 16'h0001);
      checkOutput("mid_z0_op1", core_z0, 16'h2000);
      checkOutput("mid_core_rst", 16'(core_rst), 16'h0000);
      rst = 1'b0;
      #1;
      checkOutput("arst_busy", 16'(busy), 16'h0000);
      checkOutput("arst_core_rst", 16'(core_rst), 16'h0001);
      checkOutput("arst_core_z0", core_z0, 16'h0000);
      tick(3);
      rst = 1'b1;
      tick(2);
      checkOutput("arst_no_done", 16'(doneCount - doneBase), 16'h0000);
      applyStimulus(4'd3);
      waitIdle("rerun_idle", 200);
      checkOutput("rerun_done_count", 16'(doneCount - doneBase), 16'h0001);
      checkOutput("rerun_latency", 16'(doneCyc - startCyc), 16'd73);
      checkOutput("rerun_err", 16'(err), 16'h0000);
      readRes(3'd0, rdVal); checkOutput("rerun_res0", rdVal, 16'hBFFF);
      readRes(3'd1, rdVal); checkOutput("rerun_res1", rdVal, 16'hDFFF);
      readRes(3'd2, rdVal); checkOutput("rerun_res2", rdVal, 16'hEFFF);

      $display("[TB] full buffer with writes and start while busy");
      for (int i = 0; i < 8; i++) begin
         writeOp(3'(i), fullOps[i]);
      end
      applyStimulus(4'd8);
      tick(3);
      writeOp(3'd0, 16'hAAAA);
      checkOutput("full_z0_hold", core_z0, 16'h0003);
      tick(70);
      count = 4'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitIdle("full_idle", 400);
      checkOutput("full_done_count", 16'(doneCount - doneBase), 16'h0001);
      checkOutput("full_latency", 16'(doneCyc - startCyc), 16'd193);
      checkOutput("full_err", 16'(err), 16'h0000);
      for (int i = 0; i < 8; i++) begin
         readRes(3'(i), rdVal);
         checkOutput($sformatf("full_res%0d", i), rdVal, fullExp[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
